mlp_feature_sequencer: RTL and testbench
========================================

Name: mlp_feature_sequencer

Overview:
- Clocked front end for the combinational MLP classifier `top`.
- Accepts one quantised feature per valid/ready beat and assembles the packed `inp` vector, holding it stable.
- Waits a fixed settle interval for the slow classifier, captures `out`, and returns the class over a valid/ready result channel.
- This is the hardware counterpart of the file-driven stimulus/capture bench; the inference harness and on-chip evaluation use it.

Parameters:
- WIDTH_A, 4: bits per feature.
- NUM_A, 21: features per sample.
- OUTWIDTH, 2: class index width.
- SETTLE_CYCLES, 8: cycles the vector is held before the class is sampled. Must be >= 1; checked by an elaboration-time assertion.
- CNT_W, 16: width of the completed-sample counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- feat_valid  in  1  feature beat valid.
- feat_data  in  WIDTH_A  feature value, unsigned.
- feat_ready  out  1  sequencer can accept a feature.
- inp  out  NUM_A*WIDTH_A  packed vector to classifier; feature i occupies [(i+1)*WIDTH_A-1 : i*WIDTH_A].
- cls_in  in  OUTWIDTH  classifier `out`, combinational from `inp`.
- res_valid  out  1  result available.
- res_class  out  OUTWIDTH  captured class.
- res_ready  in  1  consumer accepts result.
- busy  out  1  high when not in LOAD with idx==0.
- sample_cnt  out  CNT_W  results delivered since reset, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state=LOAD, idx=0, inp=0, res_valid=0, res_class=0, sample_cnt=0, settle counter=0, feat_ready=0 during reset.
- feat_ready is 1 only in LOAD. res_valid is 1 only in HOLD. Both are registered from the state.
- LOAD:
  - On feat_valid&&feat_ready, write feat_data into slot idx of inp.
  - If idx==NUM_A-1: idx->0, scnt->SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise idx++.
  - feat_valid low: hold.
- SETTLE:
  - inp frozen.
  - When scnt==0: res_class<=cls_in, go to HOLD.
  - Otherwise scnt--.
  - Latency: last feature accepted in cycle T; res_valid rises at T+SETTLE_CYCLES+1.
- HOLD:
  - res_class and inp stable.
  - On res_ready: res_valid->0 next cycle, sample_cnt++, go to LOAD.
  - Otherwise hold indefinitely (backpressure).
- Slots not yet rewritten keep the previous sample's values. inp is never cleared between samples. Only complete vectors are sampled.
- No feature is accepted in the cycle the result is accepted. There is exactly one bubble cycle between result handshake and the first feature of the next sample.
- feat_data and cls_in are not registered on input. res_class is registered.
- sample_cnt wraps from 2^CNT_W-1 to 0 without a flag.
- Reset mid-LOAD, SETTLE or HOLD: immediate return to reset values. The partial sample is discarded. A pending result is dropped and not counted.
- idx width = $clog2(NUM_A). Settle counter width = $clog2(SETTLE_CYCLES)+1.

Decomposition:
- Shared package mlp_seq_pkg:
  - State enum LOAD/SETTLE/HOLD.
  - Default WIDTH_A/NUM_A/OUTWIDTH constants per dataset (cardio: 4/21/2).
  - Helper localparams for idx and counter widths.
- Sub-module feature_shift_reg: the indexed slot write-enable decoder plus storage, yielding packed `inp`. The FSM, counters and result channel remain in the top.

Test Plan:
- Basic: after reset, send features 0..20 with values i%16, feat_valid held high; a stub classifier returns inp[3:0]^inp[7:4] (=1) -> res_valid rises exactly 9 cycles after the last beat, res_class=1, res_ready=1 -> sample_cnt=1, feat_ready=1 two cycles later.
- Gaps: feat_valid random 30% duty over 21 beats -> inp slot i equals the i-th accepted value, no extra or skipped beats, feat_ready=0 throughout SETTLE/HOLD.
- Backpressure: hold res_ready=0 for 50 cycles -> res_valid and res_class stable, inp unchanged, feat_ready=0; release -> single count increment.
- Reset mid-operation: assert rst_n=0 after 10 beats, and separately during HOLD -> all outputs zero, sample_cnt=0, next full sample is classified correctly.
- Wrap: CNT_W=4, deliver 17 samples -> sample_cnt reads 1.
- Stream replay: drive rows from ./../inputs.txt through the sequencer to real `top`; write res_class per line -> matches sim_outputs.txt from the stimulus bench line for line.

Source files
------------

// File: rtl/mlp_seq_pkg.sv
// Shared constants, state encoding and width helpers for the MLP feature sequencer.
package mlp_seq_pkg;

  // Cardio dataset defaults
  localparam int CARDIO_WIDTH_A  = 4;
  localparam int CARDIO_NUM_A    = 21;
  localparam int CARDIO_OUTWIDTH = 2;

  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_CNT_W         = 16;

  typedef logic [1:0] state_t;

  localparam state_t LOAD   = 2'd0;
  localparam state_t SETTLE = 2'd1;
  localparam state_t HOLD   = 2'd2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int scnt_width(input int s);
    return $clog2(s) + 1;
  endfunction

endpackage

// File: rtl/mlp_feature_sequencer_feature_shift_reg.sv
// Indexed slot storage: decodes the write index into per-slot enables and holds the packed vector.
module feature_shift_reg
  import mlp_seq_pkg::*;
#(
  parameter int WIDTH_A = CARDIO_WIDTH_A,
  parameter int NUM_A   = CARDIO_NUM_A,
  parameter int IDX_W   = idx_width(CARDIO_NUM_A)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [WIDTH_A-1:0]       din,
  output logic [NUM_A*WIDTH_A-1:0] inp
);

  logic [NUM_A-1:0] slot_we;

  always_comb begin
    slot_we = '0;
    for (int i = 0; i < NUM_A; i++) begin
      slot_we[i] = we && (idx == IDX_W'(i));
    end
  end

  // Slots are only overwritten, never cleared, so stale values persist across samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inp <= '0;
    end else begin
      for (int i = 0; i < NUM_A; i++) begin
        if (slot_we[i]) inp[i*WIDTH_A +: WIDTH_A] <= din;
      end
    end
  end

endmodule

// File: rtl/mlp_feature_sequencer.sv
// Clocked front end for the combinational MLP classifier: loads features, waits for the
// classifier to settle, then returns the class over a valid/ready result channel.
module mlp_feature_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int WIDTH_A       = CARDIO_WIDTH_A,
  parameter int NUM_A         = CARDIO_NUM_A,
  parameter int OUTWIDTH      = CARDIO_OUTWIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     feat_valid,
  input  logic [WIDTH_A-1:0]       feat_data,
  output logic                     feat_ready,
  output logic [NUM_A*WIDTH_A-1:0] inp,
  input  logic [OUTWIDTH-1:0]      cls_in,
  output logic                     res_valid,
  output logic [OUTWIDTH-1:0]      res_class,
  input  logic                     res_ready,
  output logic                     busy,
  output logic [CNT_W-1:0]         sample_cnt
);

  localparam int IDX_W  = idx_width(NUM_A);
  localparam int SCNT_W = scnt_width(SETTLE_CYCLES);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("mlp_feature_sequencer: SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  state_t             state;
  state_t             nxt;
  logic [IDX_W-1:0]   idx;
  logic [SCNT_W-1:0]  scnt;
  logic               accept;
  logic               last_beat;
  logic               res_take;

  assign accept    = feat_valid && feat_ready;
  assign last_beat = accept && (idx == IDX_W'(NUM_A - 1));
  assign res_take  = res_valid && res_ready;
  assign busy      = !((state == LOAD) && (idx == '0));

  always_comb begin
    nxt = state;
    case (state)
      LOAD:    if (last_beat) nxt = SETTLE;
      SETTLE:  if (scnt == '0) nxt = HOLD;
      HOLD:    if (res_take) nxt = LOAD;
      default: nxt = LOAD;
    endcase
  end

  // feat_ready requires a full cycle in LOAD, which creates the bubble after a result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      idx        <= '0;
      scnt       <= '0;
      feat_ready <= 1'b0;
      res_valid  <= 1'b0;
      res_class  <= '0;
      sample_cnt <= '0;
    end else begin
      state      <= nxt;
      feat_ready <= (state == LOAD) && (nxt == LOAD);
      res_valid  <= (nxt == HOLD);
      if (accept) idx <= last_beat ? '0 : idx + IDX_W'(1);
      if (last_beat) begin
        scnt <= SCNT_W'(SETTLE_CYCLES - 1);
      end else if ((state == SETTLE) && (scnt != '0)) begin
        scnt <= scnt - SCNT_W'(1);
      end
      if ((state == SETTLE) && (scnt == '0)) res_class <= cls_in;
      if (res_take) sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  feature_shift_reg #(
    .WIDTH_A (WIDTH_A),
    .NUM_A   (NUM_A),
    .IDX_W   (IDX_W)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .idx   (idx),
    .din   (feat_data),
    .inp   (inp)
  );

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Scoreboard bench for mlp_feature_sequencer driving a stub classifier out = inp[3:0]^inp[7:4].
module tb_mlp_feature_sequencer;

  localparam int WA = 4;
  localparam int NA = 21;
  localparam int OW = 2;
  localparam int ST = 8;
  localparam int CW = 4;
  localparam int VW = NA * WA;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          feat_valid = 1'b0;
  logic [WA-1:0] feat_data = '0;
  logic          feat_ready;
  logic [VW-1:0] inp;
  logic [OW-1:0] cls_in;
  logic          res_valid;
  logic [OW-1:0] res_class;
  logic          res_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] sample_cnt;

  typedef struct {
    logic [OW-1:0] cls;
    logic [VW-1:0] vec;
  } exp_t;

  exp_t          sb[$];
  int            nvec = 0;
  int            nerr = 0;
  int            exp_cnt = 0;
  logic [WA-1:0] mslot[NA];
  logic [WA-1:0] vals[NA];

  always #5 clk = ~clk;

  assign cls_in = OW'(inp[3:0] ^ inp[7:4]);

  mlp_feature_sequencer #(
    .WIDTH_A       (WA),
    .NUM_A         (NA),
    .OUTWIDTH      (OW),
    .SETTLE_CYCLES (ST),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .feat_valid (feat_valid),
    .feat_data  (feat_data),
    .feat_ready (feat_ready),
    .inp        (inp),
    .cls_in     (cls_in),
    .res_valid  (res_valid),
    .res_class  (res_class),
    .res_ready  (res_ready),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NA; i++) v[i*WA +: WA] = mslot[i];
    return v;
  endfunction

  function automatic logic [OW-1:0] model_cls(input logic [VW-1:0] v);
    logic [3:0] x;
    x = v[3:0] ^ v[7:4];
    return x[OW-1:0];
  endfunction

  // Result monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_result: got class %0h with empty scoreboard", res_class);
      end else begin
        e = sb.pop_front();
        chk("res_class", res_class, e.cls);
        chk("inp_snapshot", inp, e.vec);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_inp", inp, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_class", res_class, 0);
    chk("rst_feat_ready", feat_ready, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_busy", busy, 0);
    sb.delete();
    exp_cnt = 0;
    for (int i = 0; i < NA; i++) mslot[i] = '0;
    feat_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_release_feat_ready", feat_ready, 0);
    @(posedge clk);
    #1;
    chk("feat_ready_after_reset", feat_ready, 1);
  endtask

  // Sends the first n entries of vals; duty is the percent chance feat_valid is high per cycle.
  task automatic send_beats(input int n, input int duty);
    int   i;
    int   guard;
    logic acc;
    exp_t e;
    i = 0;
    guard = 0;
    while (i < n && guard < 5000) begin
      feat_valid = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      feat_data  = vals[i];
      acc = feat_valid && feat_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        mslot[i] = vals[i];
        i++;
      end
    end
    feat_valid = 1'b0;
    if (i < n) chk("beat_timeout", i, n);
    if (n == NA) begin
      e.vec = model_vec();
      e.cls = model_cls(e.vec);
      sb.push_back(e);
    end
  endtask

  // Called right after the last beat; junk beats are offered while settling and must be ignored.
  task automatic wait_result(input bit chk_lat);
    int lat;
    int frbad;
    int bzbad;
    lat = 1;
    frbad = 0;
    bzbad = 0;
    feat_valid = 1'b1;
    feat_data = '1;
    while (!res_valid && lat < 200) begin
      if (feat_ready) frbad++;
      if (!busy) bzbad++;
      @(posedge clk);
      #1;
      lat++;
    end
    feat_valid = 1'b0;
    chk("res_valid_seen", res_valid, 1);
    if (chk_lat) chk("latency", lat, ST + 1);
    chk("settle_feat_ready_low", frbad, 0);
    chk("settle_busy", bzbad, 0);
  endtask

  task automatic take_result(input int hold);
    logic [OW-1:0] c0;
    logic [VW-1:0] i0;
    int            bad;
    c0 = res_class;
    i0 = inp;
    bad = 0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (!res_valid || res_class !== c0 || inp !== i0 || feat_ready) bad++;
    end
    if (hold > 0) chk("backpressure_stable", bad, 0);
    res_ready = 1'b1;
    exp_cnt++;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("sample_cnt", sample_cnt, exp_cnt % 16);
    chk("res_valid_drop", res_valid, 0);
    chk("bubble_feat_ready", feat_ready, 0);
    chk("bubble_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("feat_ready_back", feat_ready, 1);
  endtask

  initial begin
    #2;
    do_reset();

    for (int i = 0; i < NA; i++) vals[i] = WA'(i % 16);
    send_beats(NA, 100);
    wait_result(1);
    chk("basic_class", res_class, 1);
    take_result(0);

    for (int i = 0; i < NA; i++) vals[i] = WA'((i * 6 + 2) % 16);
    send_beats(NA, 30);
    wait_result(1);
    chk("gaps_class", res_class, 2);
    take_result(0);

    for (int i = 0; i < NA; i++) vals[i] = WA'((i * 9 + 3) % 16);
    send_beats(NA, 100);
    wait_result(1);
    chk("bp_class", res_class, 3);
    take_result(50);
    chk("bp_count", sample_cnt, 3);

    for (int i = 0; i < NA; i++) vals[i] = WA'((i + 11) % 16);
    send_beats(10, 100);
    chk("partial_inp_keeps_old", inp, model_vec());
    chk("partial_busy", busy, 1);
    do_reset();

    for (int i = 0; i < NA; i++) vals[i] = WA'(i % 16);
    send_beats(NA, 100);
    wait_result(1);
    chk("post_load_reset_class", res_class, 1);
    take_result(0);

    for (int i = 0; i < NA; i++) vals[i] = WA'((i * 6 + 2) % 16);
    send_beats(NA, 100);
    wait_result(1);
    do_reset();
    for (int i = 0; i < NA; i++) vals[i] = WA'(i % 16);
    send_beats(NA, 100);
    wait_result(1);
    chk("post_hold_reset_class", res_class, 1);
    take_result(0);
    chk("post_hold_reset_count", sample_cnt, 1);

    do_reset();
    for (int s = 0; s < 17; s++) begin
      for (int i = 0; i < NA; i++) vals[i] = WA'((s * 5 + i * 3) % 16);
      send_beats(NA, (s % 2 == 1) ? 50 : 100);
      wait_result(0);
      take_result(0);
    end
    chk("wrap_count", sample_cnt, 1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
